ram_rr_arb: RTL and testbench

RAM_RR_ARB -- requirements
Module: ram_rr_arb

---
 rtl/ram_rr_arb.sv | 127 ++++++++++++
 tb/tb_ram_rr_arb.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_rr_arb.sv
// Two-requester round-robin arbiter in front of a 16x4 synchronous RAM.
// One transaction in flight; grants, read-valid pulses and RAM commands are registered.
module ram_rr_arb #(
    parameter int FIRST = 0
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       REQ0,
    input  logic       REQ1,
    input  logic       WR0,
    input  logic       WR1,
    input  logic [3:0] A0,
    input  logic [3:0] A1,
    input  logic [3:0] D0,
    input  logic [3:0] D1,
    output logic       GNT0,
    output logic       GNT1,
    output logic       RVLD0,
    output logic       RVLD1,
    output logic [3:0] RDATA,
    output logic       RAM_EN,
    output logic       RAM_WR,
    output logic [3:0] RAM_A,
    output logic [3:0] RAM_D,
    input  logic [3:0] RAM_Q
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RDWAIT = 2'd2
    } state_t;

    // LAST starts opposite to FIRST so that FIRST wins the first contention.
    localparam logic LAST_RST = (FIRST == 0) ? 1'b1 : 1'b0;

    state_t state_r;
    state_t state_nxt_s;
    logic   last_r;
    logic   id_r;
    logic   win_s;
    logic   accept_s;

    function automatic logic rr_pick(input logic r0, input logic r1, input logic last);
        if (r0 && r1) begin
            rr_pick = ~last;
        end else if (r1) begin
            rr_pick = 1'b1;
        end else begin
            rr_pick = 1'b0;
        end
    endfunction

    // Next-state logic; requests are only looked at in IDLE.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        win_s       = rr_pick(REQ0, REQ1, last_r);
        case (state_r)
            IDLE: begin
                if (REQ0 || REQ1) begin
                    accept_s    = 1'b1;
                    state_nxt_s = ISSUE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ISSUE: begin
                if (RAM_WR) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RDWAIT;
                end
            end
            RDWAIT:  state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Winner's command is latched straight into the RAM address/data/type registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            last_r <= LAST_RST;
            id_r   <= 1'b0;
            RAM_WR <= 1'b0;
            RAM_A  <= 4'h0;
            RAM_D  <= 4'h0;
        end else if (accept_s) begin
            last_r <= win_s;
            id_r   <= win_s;
            RAM_WR <= win_s ? WR1 : WR0;
            RAM_A  <= win_s ? A1  : A0;
            RAM_D  <= win_s ? D1  : D0;
        end
    end

    // One-cycle pulses and read-data capture; RDATA holds between reads.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            GNT0   <= 1'b0;
            GNT1   <= 1'b0;
            RAM_EN <= 1'b0;
            RVLD0  <= 1'b0;
            RVLD1  <= 1'b0;
            RDATA  <= 4'h0;
        end else begin
            GNT0   <= accept_s && !win_s;
            GNT1   <= accept_s && win_s;
            RAM_EN <= accept_s;
            RVLD0  <= (state_r == RDWAIT) && !id_r;
            RVLD1  <= (state_r == RDWAIT) && id_r;
            if (state_r == RDWAIT) begin
                RDATA <= RAM_Q;
            end
        end
    end

endmodule

// File: tb/tb_ram_rr_arb.sv
// Scoreboard bench for ram_rr_arb: transaction-level round-robin model feeds
// expected grants/read results; a monitor compares every cycle.
module tb_ram_rr_arb;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       REQ0 = 1'b0, REQ1 = 1'b0, WR0 = 1'b0, WR1 = 1'b0;
    logic [3:0] A0 = 4'h0, A1 = 4'h0, D0 = 4'h0, D1 = 4'h0;
    logic       GNT0, GNT1, RVLD0, RVLD1, RAM_EN, RAM_WR;
    logic [3:0] RDATA, RAM_A, RAM_D;
    logic [3:0] RAM_Q = 4'h0;

    ram_rr_arb #(.FIRST(0)) dut (
        .CLK(CLK), .RST(RST),
        .REQ0(REQ0), .REQ1(REQ1), .WR0(WR0), .WR1(WR1),
        .A0(A0), .A1(A1), .D0(D0), .D1(D1),
        .GNT0(GNT0), .GNT1(GNT1), .RVLD0(RVLD0), .RVLD1(RVLD1),
        .RDATA(RDATA), .RAM_EN(RAM_EN), .RAM_WR(RAM_WR),
        .RAM_A(RAM_A), .RAM_D(RAM_D), .RAM_Q(RAM_Q)
    );

    always #5 CLK = ~CLK;

    // 16x4 RAM with registered read data; contents survive reset.
    logic [3:0] mem [16];
    always @(posedge CLK) begin
        if (RAM_EN) begin
            if (RAM_WR) mem[RAM_A] <= RAM_D & 4'hF;
            else        RAM_Q <= mem[RAM_A];
        end
    end

    typedef struct {
        int         cyc;
        logic       id;
        logic       wr;
        logic [3:0] a;
        logic [3:0] d;
    } exp_t;

    exp_t gq[$];
    exp_t rq[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    // reference model state
    logic [3:0] shadow [16];
    logic       last;
    int         busy;
    int         mode;
    logic       p_v [2];
    logic       p_wr [2];
    logic [3:0] p_a [2];
    logic [3:0] p_d [2];
    logic       clr [2];

    task automatic chk(input string nm, input int act, input int exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    task automatic clear_model();
        gq.delete();
        rq.delete();
        last = 1'b1;
        busy = 0;
        for (int i = 0; i < 2; i++) begin
            p_v[i] = 1'b0; p_wr[i] = 1'b0; p_a[i] = 4'h0; p_d[i] = 4'h0; clr[i] = 1'b0;
        end
        REQ0 = 1'b0; REQ1 = 1'b0; WR0 = 1'b0; WR1 = 1'b0;
        A0 = 4'h0; A1 = 4'h0; D0 = 4'h0; D1 = 4'h0;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        clear_model();
        repeat (2) @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic set_req(input int i, input logic wr, input logic [3:0] a, input logic [3:0] d);
        p_v[i] = 1'b1; p_wr[i] = wr; p_a[i] = a; p_d[i] = d;
    endtask

    // One cycle of stimulus plus the transaction-level arbitration model.
    task automatic step();
        exp_t e;
        logic w;
        @(negedge CLK);
        for (int i = 0; i < 2; i++) begin
            if (!p_v[i] && (mode == 1 || (mode == 2 && $urandom_range(1, 0) == 1))) begin
                p_v[i]  = 1'b1;
                p_wr[i] = (mode == 1) ? 1'b1 : 1'($urandom_range(1, 0));
                p_a[i]  = 4'($urandom_range(15, 0));
                p_d[i]  = 4'($urandom_range(15, 0));
            end
        end
        REQ0 = p_v[0]; WR0 = p_wr[0]; A0 = p_a[0]; D0 = p_d[0];
        REQ1 = p_v[1]; WR1 = p_wr[1]; A1 = p_a[1]; D1 = p_d[1];
        for (int i = 0; i < 2; i++) begin
            if (clr[i]) begin
                p_v[i] = 1'b0;
                clr[i] = 1'b0;
            end
        end
        if (busy > 0) begin
            busy--;
        end else if (p_v[0] || p_v[1]) begin
            w = (p_v[0] && p_v[1]) ? ~last : p_v[1];
            e.cyc = cyc + 1; e.id = w; e.wr = p_wr[w]; e.a = p_a[w]; e.d = p_d[w];
            gq.push_back(e);
            if (e.wr) begin
                shadow[e.a] = e.d;
                busy = 1;
            end else begin
                e.cyc = cyc + 3;
                e.d = shadow[e.a];
                rq.push_back(e);
                busy = 2;
            end
            last = w;
            clr[w] = 1'b1;
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    // Monitor: compares DUT outputs against the scoreboard queues every cycle.
    initial begin
        logic       g, r;
        exp_t       ge, re;
        logic [3:0] exp_rdata, exp_a, exp_d;
        exp_rdata = 4'h0; exp_a = 4'h0; exp_d = 4'h0;
        forever begin
            @(posedge CLK);
            cyc++;
            #1;
            if (RST) begin
                exp_rdata = 4'h0; exp_a = 4'h0; exp_d = 4'h0;
                chk("reset_outputs",
                    int'({GNT0, GNT1, RVLD0, RVLD1, RAM_EN, RAM_WR, RAM_A, RAM_D, RDATA}), 0);
            end else begin
                g = (gq.size() > 0) && (gq[0].cyc == cyc);
                r = (rq.size() > 0) && (rq[0].cyc == cyc);
                if (g) ge = gq.pop_front();
                if (r) re = rq.pop_front();
                chk("gnt0", int'(GNT0), int'(g && !ge.id));
                chk("gnt1", int'(GNT1), int'(g && ge.id));
                chk("ram_en", int'(RAM_EN), int'(g));
                if (g) begin
                    exp_a = ge.a;
                    exp_d = ge.d;
                    chk("ram_wr", int'(RAM_WR), int'(ge.wr));
                end
                chk("ram_a", int'(RAM_A), int'(exp_a));
                chk("ram_d", int'(RAM_D), int'(exp_d));
                chk("rvld0", int'(RVLD0), int'(r && !re.id));
                chk("rvld1", int'(RVLD1), int'(r && re.id));
                if (r) exp_rdata = re.d;
                chk("rdata", int'(RDATA), int'(exp_rdata));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem[i] = 4'h0;
            shadow[i] = 4'h0;
        end
        mode = 0;
        clear_model();
        do_reset();
        run(2);
        // lone write then read-back by the other requester
        set_req(0, 1'b1, 4'h5, 4'hA);
        run(3);
        set_req(1, 1'b0, 4'h5, 4'h0);
        run(4);
        // read by 0 with a write by 1 arriving in the RVLD0 cycle
        set_req(0, 1'b0, 4'h5, 4'h0);
        run(3);
        set_req(1, 1'b1, 4'h3, 4'h6);
        run(4);
        // continuous contention of writes
        mode = 1;
        run(24);
        mode = 0;
        run(4);
        // randomized traffic
        mode = 2;
        run(2000);
        mode = 0;
        run(6);
        // reset during RDWAIT of a read, then contention
        set_req(0, 1'b0, 4'h3, 4'h0);
        run(2);
        do_reset();
        set_req(0, 1'b1, 4'h7, 4'h1);
        set_req(1, 1'b1, 4'h8, 4'h2);
        run(8);
        // read back what both wrote
        set_req(1, 1'b0, 4'h7, 4'h0);
        run(4);
        set_req(0, 1'b0, 4'h8, 4'h0);
        run(6);
        chk("queues_drained", gq.size() + rq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
